ledmatrix_frame_arbiter: RTL and testbench

Shares the 8x8 LED matrix scan driver between two frame requesters, such as a game renderer and a text scroller. Frame data is latched into an output register only on driver scan-frame boundaries, so the matrix never shows a torn image. A granted source keeps the display for a minimum number of scan frames; after that, ownership passes round-robin. The block sits directly upstream of the matrix driver, feeding its `matdata` and `en` inputs.

---
 rtl/ledmatrix_frame_arbiter.sv | 97 +++++++++
 tb/tb_ledmatrix_frame_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ledmatrix_frame_arbiter.sv
// Two-requester arbiter for the 8x8 LED matrix driver. Frames are latched only on
// scan-frame boundaries, and ownership rotates round-robin after a minimum dwell.
module ledmatrix_frame_arbiter #(
  parameter int DWELL_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [7:0][7:0] frame0,
  input  logic [7:0][7:0] frame1,
  input  logic            frame_done,
  output logic [7:0][7:0] matdata,
  output logic            en,
  output logic [1:0]      ack,
  output logic            owner,
  output logic            dbg_state_o
);

  // Handshake: req[i] is a level that may stay high indefinitely; ack[i] pulses for
  // exactly one cycle whenever a frame from requester i appears on matdata.
  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  localparam logic [7:0] DWELL_MAX = 8'(DWELL_FRAMES - 1);

  state_t          state_q;
  logic [7:0][7:0] matdata_q;
  logic [1:0]      ack_q;
  logic            owner_q;
  logic            last_q;
  logic [7:0]      dwell_q;

  logic            other;
  logic            idle_pick;
  logic            do_switch;
  logic [7:0][7:0] frame_own;
  logic [7:0][7:0] frame_other;
  logic [7:0][7:0] frame_pick;

  assign other       = ~owner_q;
  // On a tie the requester that did not own the display last time wins.
  assign idle_pick   = (req == 2'b11) ? ~last_q : req[1];
  assign do_switch   = req[other] && (!req[owner_q] || (dwell_q == DWELL_MAX));
  assign frame_own   = owner_q   ? frame1 : frame0;
  assign frame_other = other     ? frame1 : frame0;
  assign frame_pick  = idle_pick ? frame1 : frame0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      matdata_q <= '0;
      ack_q     <= 2'b00;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      dwell_q   <= 8'd0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            state_q   <= SHOW;
            owner_q   <= idle_pick;
            last_q    <= idle_pick;
            matdata_q <= frame_pick;
            ack_q     <= idle_pick ? 2'b10 : 2'b01;
            dwell_q   <= 8'd0;
          end
        end
        SHOW: begin
          if (frame_done) begin
            if (do_switch) begin
              owner_q   <= other;
              last_q    <= other;
              matdata_q <= frame_other;
              ack_q     <= other ? 2'b10 : 2'b01;
              dwell_q   <= 8'd0;
            end else if (req[owner_q]) begin
              matdata_q <= frame_own;
              ack_q     <= owner_q ? 2'b10 : 2'b01;
              if (dwell_q != DWELL_MAX) dwell_q <= dwell_q + 8'd1;
            end else begin
              state_q   <= IDLE;
              matdata_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign matdata     = matdata_q;
  assign en          = (state_q == SHOW);
  assign ack         = ack_q;
  assign owner       = owner_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ledmatrix_frame_arbiter.sv
// Bench for ledmatrix_frame_arbiter: a boundary-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ledmatrix_frame_arbiter;

  localparam int DWELL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req;
  logic [7:0][7:0] frame0;
  logic [7:0][7:0] frame1;
  logic            frame_done;
  logic [7:0][7:0] matdata;
  logic            en;
  logic [1:0]      ack;
  logic            owner;
  logic            dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock/reset block.
  always #5 clk = ~clk;

  ledmatrix_frame_arbiter #(.DWELL_FRAMES(DWELL)) dut (
    .clk(clk), .rst(rst), .req(req), .frame0(frame0), .frame1(frame1),
    .frame_done(frame_done), .matdata(matdata), .en(en), .ack(ack),
    .owner(owner), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner tenure counted as boundaries since grant.
  logic            m_show  = 1'b0;
  logic            m_owner = 1'b0;
  logic            m_last  = 1'b1;
  int              m_held  = 0;
  logic [63:0]     m_mat   = '0;
  logic [1:0]      m_ack   = 2'b00;

  task automatic m_grant(input logic w);
    m_show  = 1'b1;
    m_owner = w;
    m_last  = w;
    m_mat   = w ? frame1 : frame0;
    m_ack   = 2'b00;
    m_ack[w] = 1'b1;
    m_held  = 0;
  endtask

  always @(posedge clk) begin
    logic o, x;
    m_ack = 2'b00;
    if (rst) begin
      m_show = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_held = 0; m_mat = '0;
    end else if (!m_show) begin
      if (req != 2'b00) m_grant((req == 2'b11) ? !m_last : req[1]);
    end else if (frame_done) begin
      o = m_owner;
      x = !o;
      if (req[x] && (!req[o] || m_held >= DWELL - 1)) m_grant(x);
      else if (req[o]) begin
        m_mat    = o ? frame1 : frame0;
        m_ack[o] = 1'b1;
        m_held++;
      end else begin
        m_show = 1'b0;
        m_mat  = '0;
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge.
  always @(posedge clk) begin
    #2;
    check("model_en", {63'd0, en}, {63'd0, m_show});
    check("model_matdata", matdata, m_show ? m_mat : 64'd0);
    check("model_ack", {62'd0, ack}, {62'd0, m_ack});
    check("model_state", {63'd0, dbg_state}, {63'd0, m_show});
    if (m_show) check("model_owner", {63'd0, owner}, {63'd0, m_owner});
  end

  // Driver tasks: inputs change 3 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic boundary();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic e_en, input logic [63:0] e_mat,
                            input logic [1:0] e_ack, input logic e_owner);
    check({name, "_en"}, {63'd0, en}, {63'd0, e_en});
    check({name, "_mat"}, matdata, e_mat);
    check({name, "_ack"}, {62'd0, ack}, {62'd0, e_ack});
    check({name, "_owner"}, {63'd0, owner}, {63'd0, e_owner});
  endtask

  localparam logic [63:0] FA = 64'hA5A5_0101_3C3C_7E7E;
  localparam logic [63:0] FB = 64'h1234_5678_9ABC_DEF0;

  initial begin
    logic e_own;
    rst = 1'b1; req = 2'b11; frame0 = FA; frame1 = FB; frame_done = 1'b0;

    // Reset held three cycles with both requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset", 1'b0, 64'd0, 2'b00, 1'b0);
    end
    rst = 1'b0;
    tick();
    expect_out("first_grant", 1'b1, FA, 2'b01, 1'b0);

    // Dwell and round-robin: three refreshes, switch on the 4th boundary, and back.
    for (int i = 1; i <= 8; i++) begin
      boundary();
      e_own = (i >= 4 && i < 8);
      expect_out("dwell_rr", 1'b1, e_own ? FB : FA, e_own ? 2'b10 : 2'b01, e_own);
      tick();
      check("dwell_rr_noack", {62'd0, ack}, 64'd0);
    end

    // Go idle: outputs hold until the boundary, then clear.
    req = 2'b00;
    tick();
    expect_out("idle_hold", 1'b1, FA, 2'b00, 1'b0);
    boundary();
    check("idle_en", {63'd0, en}, 64'd0);
    check("idle_mat", matdata, 64'd0);
    check("idle_ack", {62'd0, ack}, 64'd0);
    tick();
    check("idle_stays", {63'd0, en}, 64'd0);
    req = 2'b11;
    tick();
    expect_out("regrant_rr", 1'b1, FB, 2'b10, 1'b1);

    // Single requester refresh with a mid-frame data change.
    req = 2'b10;
    frame1 = 64'h0011223344556677;
    boundary();
    expect_out("single_a", 1'b1, 64'h0011223344556677, 2'b10, 1'b1);
    frame1 = 64'hFF00FF00FF00FF00;
    tick();
    tick();
    expect_out("single_hold", 1'b1, 64'h0011223344556677, 2'b00, 1'b1);
    boundary();
    expect_out("single_b", 1'b1, 64'hFF00FF00FF00FF00, 2'b10, 1'b1);

    // Early release: owner 0 at dwell 1 drops its request.
    req = 2'b01;
    boundary();
    expect_out("to_owner0", 1'b1, FA, 2'b01, 1'b0);
    req = 2'b11;
    boundary();
    expect_out("owner0_dwell1", 1'b1, FA, 2'b01, 1'b0);
    req = 2'b10;
    frame1 = 64'h0F0F_F0F0_0F0F_F0F0;
    tick();
    expect_out("early_wait", 1'b1, FA, 2'b00, 1'b0);
    boundary();
    expect_out("early_switch", 1'b1, 64'h0F0F_F0F0_0F0F_F0F0, 2'b10, 1'b1);

    // Reset on the same edge as a boundary.
    req = 2'b01;
    rst = 1'b1;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    expect_out("rst_mid", 1'b0, 64'd0, 2'b00, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("after_rst", 1'b1, FA, 2'b01, 1'b0);

    // Short run of random boundaries and requests, checked by the model.
    for (int i = 0; i < 60; i++) begin
      req        = 2'($urandom_range(0, 3));
      frame_done = ($urandom_range(0, 2) == 0);
      frame0     = {$urandom, $urandom};
      frame1     = {$urandom, $urandom};
      tick();
    end
    frame_done = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
